// File: rtl/task_scheduler_wrr_if.sv
// Push/pop/config/command bundle for the weighted round-robin task scheduler.
interface task_scheduler_wrr_if #(
  parameter int unsigned TREE_NUM   = 4,
  parameter int unsigned PTW        = 16,
  parameter int unsigned MTW        = $clog2(TREE_NUM),
  parameter int unsigned CTW        = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned WTW        = 4
);
  logic                          i_push;
  logic [MTW-1:0]                i_push_tree_id;
  logic [PTW-1:0]                i_push_priority;
  logic [MTW+PTW-1:0]            i_push_data;
  logic                          o_push_ready;
  logic                          i_pop;
  logic                          o_pop_valid;
  logic [MTW-1:0]                o_pop_tree_id;
  logic                          o_pop_empty;
  logic                          i_cfg_we;
  logic [MTW-1:0]                i_cfg_tree_id;
  logic [WTW-1:0]                i_cfg_weight;
  logic                          o_cmd_valid;
  logic                          i_cmd_ready;
  logic                          o_cmd_push;
  logic [MTW-1:0]                o_cmd_tree_id;
  logic [PTW-1:0]                o_cmd_priority;
  logic [MTW+PTW-1:0]            o_cmd_data;
  logic [TREE_NUM*CTW-1:0]       o_tree_count;
  logic [$clog2(FIFO_DEPTH):0]   o_fifo_count;
  logic                          o_overflow;

  modport slave (
    input  i_push, i_push_tree_id, i_push_priority, i_push_data, i_pop,
    input  i_cfg_we, i_cfg_tree_id, i_cfg_weight, i_cmd_ready,
    output o_push_ready, o_pop_valid, o_pop_tree_id, o_pop_empty,
    output o_cmd_valid, o_cmd_push, o_cmd_tree_id, o_cmd_priority, o_cmd_data,
    output o_tree_count, o_fifo_count, o_overflow
  );

  modport master (
    output i_push, i_push_tree_id, i_push_priority, i_push_data, i_pop,
    output i_cfg_we, i_cfg_tree_id, i_cfg_weight, i_cmd_ready,
    input  o_push_ready, o_pop_valid, o_pop_tree_id, o_pop_empty,
    input  o_cmd_valid, o_cmd_push, o_cmd_tree_id, o_cmd_priority, o_cmd_data,
    input  o_tree_count, o_fifo_count, o_overflow
  );
endinterface

// File: rtl/task_scheduler_wrr.sv
// Weighted round-robin pop arbiter over per-tree occupancy counters, feeding a
// show-ahead command FIFO that preserves acceptance order of pushes and granted pops.
module task_scheduler_wrr #(
  parameter int unsigned TREE_NUM   = 4,
  parameter int unsigned PTW        = 16,
  parameter int unsigned MTW        = $clog2(TREE_NUM),
  parameter int unsigned CTW        = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned WTW        = 4
) (
  input  logic                 i_clk,
  input  logic                 i_arst_n,
  task_scheduler_wrr_if.slave  bus
);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW = AW + 1;
  localparam int unsigned DW  = MTW + PTW;

  typedef struct packed {
    logic           push;
    logic [MTW-1:0] tree;
    logic [PTW-1:0] prio;
    logic [DW-1:0]  data;
  } cmd_t;

  cmd_t           mem_q [FIFO_DEPTH];
  cmd_t           enq_cmd, head;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CTW-1:0] count_q [TREE_NUM];
  logic [CTW-1:0] count_d [TREE_NUM];
  logic [WTW-1:0] weight_q [TREE_NUM];
  logic [MTW-1:0] ptr_q, ptr_d, grant_tree, scan_idx, pop_tree_q;
  logic [WTW-1:0] credit_q, credit_d, reload_w;
  logic           pop_valid_q, pop_empty_q, overflow_q;
  logic           fifo_full, fifo_empty, pop_eval, any_busy, pop_grant;
  logic           push_acc, push_sat, push_enq, enq, deq, found;

  assign fifo_full       = (fifo_cnt_q == FCW'(FIFO_DEPTH));
  assign fifo_empty      = (fifo_cnt_q == '0);
  assign bus.o_push_ready = !fifo_full && !bus.i_pop;
  assign pop_eval        = bus.i_pop && !fifo_full;
  assign push_acc        = bus.i_push && bus.o_push_ready;
  assign push_sat        = &count_q[bus.i_push_tree_id];
  assign push_enq        = push_acc && !push_sat;
  assign pop_grant       = pop_eval && any_busy;
  assign enq             = pop_grant || push_enq;
  assign deq             = !fifo_empty && bus.i_cmd_ready;

  // Stay on ptr while it has credit and work; otherwise the scan ends back at ptr itself.
  always_comb begin
    any_busy   = 1'b0;
    found      = 1'b0;
    grant_tree = ptr_q;
    scan_idx   = ptr_q;
    ptr_d      = ptr_q;
    credit_d   = credit_q;
    reload_w   = '0;
    for (int t = 0; t < int'(TREE_NUM); t++) begin
      any_busy = any_busy | (count_q[t] != '0);
    end
    if (count_q[ptr_q] != '0 && credit_q != '0) begin
      credit_d = credit_q - WTW'(1);
    end else begin
      for (int k = 1; k <= int'(TREE_NUM); k++) begin
        scan_idx = MTW'((int'(ptr_q) + k) % int'(TREE_NUM));
        if (!found && count_q[scan_idx] != '0) begin
          found      = 1'b1;
          grant_tree = scan_idx;
        end
      end
      reload_w = (weight_q[grant_tree] == '0) ? WTW'(1) : weight_q[grant_tree];
      ptr_d    = grant_tree;
      credit_d = reload_w - WTW'(1);
    end
  end

  always_comb begin
    for (int t = 0; t < int'(TREE_NUM); t++) begin
      count_d[t] = count_q[t];
      if (pop_grant && grant_tree == MTW'(t)) begin
        count_d[t] = count_q[t] - CTW'(1);
      end else if (push_enq && bus.i_push_tree_id == MTW'(t)) begin
        count_d[t] = count_q[t] + CTW'(1);
      end
    end
  end

  always_comb begin
    enq_cmd = '0;
    if (pop_grant) begin
      enq_cmd.tree = grant_tree;
    end else begin
      enq_cmd.push = 1'b1;
      enq_cmd.tree = bus.i_push_tree_id;
      enq_cmd.prio = bus.i_push_priority;
      enq_cmd.data = bus.i_push_data;
    end
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (enq && !deq) begin
      fifo_cnt_d = fifo_cnt_q + FCW'(1);
    end else if (!enq && deq) begin
      fifo_cnt_d = fifo_cnt_q - FCW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      ptr_q       <= MTW'(TREE_NUM - 1);
      credit_q    <= '0;
      pop_valid_q <= 1'b0;
      pop_empty_q <= 1'b0;
      pop_tree_q  <= '0;
      overflow_q  <= 1'b0;
      for (int t = 0; t < int'(TREE_NUM); t++) begin
        count_q[t]  <= '0;
        weight_q[t] <= WTW'(1);
      end
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + AW'(1);
      fifo_cnt_q <= fifo_cnt_d;
      for (int t = 0; t < int'(TREE_NUM); t++) begin
        count_q[t] <= count_d[t];
      end
      if (pop_grant) begin
        ptr_q      <= ptr_d;
        credit_q   <= credit_d;
        pop_tree_q <= grant_tree;
      end
      pop_valid_q <= pop_grant;
      pop_empty_q <= pop_eval && !any_busy;
      if (push_acc && push_sat) overflow_q <= 1'b1;
      if (bus.i_cfg_we) weight_q[bus.i_cfg_tree_id] <= bus.i_cfg_weight;
    end
  end

  // Storage needs no reset: the head fields are masked while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (enq) mem_q[wr_ptr_q] <= enq_cmd;
  end

  assign head               = mem_q[rd_ptr_q];
  assign bus.o_cmd_valid    = !fifo_empty;
  assign bus.o_cmd_push     = !fifo_empty && head.push;
  assign bus.o_cmd_tree_id  = fifo_empty ? '0 : head.tree;
  assign bus.o_cmd_priority = fifo_empty ? '0 : head.prio;
  assign bus.o_cmd_data     = fifo_empty ? '0 : head.data;
  assign bus.o_fifo_count   = fifo_cnt_q;
  assign bus.o_pop_valid    = pop_valid_q;
  assign bus.o_pop_empty    = pop_empty_q;
  assign bus.o_pop_tree_id  = pop_tree_q;
  assign bus.o_overflow     = overflow_q;

  always_comb begin
    bus.o_tree_count = '0;
    for (int t = 0; t < int'(TREE_NUM); t++) begin
      bus.o_tree_count[t*CTW +: CTW] = count_q[t];
    end
  end
endmodule

// File: tb/tb_task_scheduler_wrr.sv
// Bench for task_scheduler_wrr: directed vector table, corner sequences and a
// randomized run, all checked every cycle against a queue-based reference model.
module tb_task_scheduler_wrr;
  localparam int TN  = 4;
  localparam int PTW = 16;
  localparam int MTW = 2;
  localparam int CTW = 4;
  localparam int FD  = 16;
  localparam int WTW = 4;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  task_scheduler_wrr_if #(.TREE_NUM(TN), .PTW(PTW), .MTW(MTW), .CTW(CTW), .FIFO_DEPTH(FD),
                          .WTW(WTW)) bus ();

  task_scheduler_wrr #(.TREE_NUM(TN), .PTW(PTW), .MTW(MTW), .CTW(CTW), .FIFO_DEPTH(FD),
                       .WTW(WTW)) dut (.i_clk(clk), .i_arst_n(arst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: command queue, per-tree counts, weights, WRR pointer and credit.
  typedef struct { bit push; int tree; int prio; int data; } mcmd_t;
  mcmd_t mq[$];
  int mcnt[TN];
  int mw[TN];
  int mptr, mcredit, m_pt;
  bit movf, m_pv, m_pe, m_rst;

  typedef struct {
    bit push; bit pop; bit rdy; int tree; int prio; int data;
    int exp_fifo; bit exp_pv; int exp_pt;
  } vec_t;
  vec_t vecs[32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    for (int t = 0; t < TN; t++) begin
      mcnt[t] = 0;
      mw[t] = 1;
    end
    mptr = TN - 1; mcredit = 0; movf = 0; m_pv = 0; m_pe = 0; m_pt = 0; m_rst = 1;
  endfunction

  function automatic void model_step(bit push, int tree, int prio, int data, bit pop, bit rdy,
                                     bit we, int ctree, int cw);
    bit full, any, enq;
    mcmd_t c;
    int g;
    full = (mq.size() == FD);
    any = 0; enq = 0; g = -1;
    m_pv = 0; m_pe = 0; m_rst = 0;
    for (int t = 0; t < TN; t++) any |= (mcnt[t] != 0);
    if (pop && !full) begin
      if (!any) m_pe = 1;
      else begin
        if (mcnt[mptr] != 0 && mcredit != 0) begin
          g = mptr;
          mcredit--;
        end else begin
          for (int k = 1; k <= TN; k++)
            if (g < 0 && mcnt[(mptr + k) % TN] != 0) g = (mptr + k) % TN;
          mptr = g;
          mcredit = ((mw[g] == 0) ? 1 : mw[g]) - 1;
        end
        mcnt[g]--;
        m_pv = 1; m_pt = g;
        c = '{0, g, 0, 0};
        enq = 1;
      end
    end else if (push && !full && !pop) begin
      if (mcnt[tree] == (1 << CTW) - 1) movf = 1;
      else begin
        mcnt[tree]++;
        c = '{1, tree, prio, data};
        enq = 1;
      end
    end
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    if (enq) mq.push_back(c);
    if (we) mw[ctree] = cw;
  endfunction

  task automatic check_all();
    logic [63:0] tc;
    tc = '0;
    for (int t = 0; t < TN; t++) tc |= 64'(mcnt[t]) << (t * CTW);
    if (mq.size() > 0) begin
      chk("cmd_valid", bus.o_cmd_valid, 1);
      chk("cmd_push", bus.o_cmd_push, mq[0].push);
      chk("cmd_tree", bus.o_cmd_tree_id, mq[0].tree);
      chk("cmd_prio", bus.o_cmd_priority, mq[0].prio);
      chk("cmd_data", bus.o_cmd_data, mq[0].data);
    end else begin
      chk("cmd_valid", bus.o_cmd_valid, 0);
      chk("cmd_fields", {bus.o_cmd_push, bus.o_cmd_tree_id, bus.o_cmd_priority, bus.o_cmd_data},
          0);
    end
    chk("fifo_count", bus.o_fifo_count, mq.size());
    chk("tree_count", bus.o_tree_count, tc);
    chk("overflow", bus.o_overflow, movf);
    chk("pop_valid", bus.o_pop_valid, m_pv);
    chk("pop_empty", bus.o_pop_empty, m_pe);
    if (m_pv || m_rst) chk("pop_tree", bus.o_pop_tree_id, m_pt);
  endtask

  task automatic step(input bit push, input int tree, input int prio, input int data,
                      input bit pop, input bit rdy, input bit we = 0, input int ctree = 0,
                      input int cw = 0, input bit rst_n = 1);
    bus.i_push = push; bus.i_push_tree_id = MTW'(tree);
    bus.i_push_priority = PTW'(prio); bus.i_push_data = (MTW + PTW)'(data);
    bus.i_pop = pop; bus.i_cmd_ready = rdy;
    bus.i_cfg_we = we; bus.i_cfg_tree_id = MTW'(ctree); bus.i_cfg_weight = WTW'(cw);
    arst_n = rst_n;
    #1;
    chk("push_ready", bus.o_push_ready, (mq.size() != FD) && !pop);
    if (!rst_n) model_reset();
    else model_step(push, tree, prio, data, pop, rdy, we, ctree, cw);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input bit rdy, input bit rst_n = 1);
    step(0, 0, 0, 0, 0, rdy, 0, 0, 0, rst_n);
  endtask

  task automatic run_vec(input int i);
    step(vecs[i].push, vecs[i].tree, vecs[i].prio, vecs[i].data, vecs[i].pop, vecs[i].rdy);
    chk($sformatf("vec%0d fifo_count", i), bus.o_fifo_count, vecs[i].exp_fifo);
    chk($sformatf("vec%0d pop_valid", i), bus.o_pop_valid, vecs[i].exp_pv);
    if (vecs[i].exp_pv) chk($sformatf("vec%0d pop_tree", i), bus.o_pop_tree_id, vecs[i].exp_pt);
  endtask

  initial begin
    int k;
    k = 0;
    for (int i = 1; i <= 3; i++)
      for (int j = 1; j <= 4; j++) begin
        vecs[k] = '{1, 0, 0, i, i, 4096 * i + j, k + 1, 0, 0};
        k++;
      end
    for (int j = 1; j <= 4; j++) vecs[11 + j] = '{1, 0, 0, 0, 0, j, 12 + j, 0, 0};
    for (int p = 0; p < 12; p++) vecs[16 + p] = '{0, 1, 1, 0, 0, 0, 12, 1, 1 + p % 3};
    vecs[28] = '{0, 1, 1, 0, 0, 0, 12, 1, 1};
    vecs[29] = '{0, 1, 1, 0, 0, 0, 12, 1, 1};
    vecs[30] = '{0, 1, 1, 0, 0, 0, 12, 1, 2};
    vecs[31] = '{0, 1, 1, 0, 0, 0, 12, 1, 3};

    // Reset state with idle inputs.
    idle(0, 0);
    idle(0);
    chk("reset cmd_valid", bus.o_cmd_valid, 0);
    chk("reset fifo_count", bus.o_fifo_count, 0);
    chk("reset push_ready", bus.o_push_ready, 1);

    // Fill to 12, then to full.
    for (int i = 0; i < 12; i++) run_vec(i);
    chk("fill12 tree_count", bus.o_tree_count, 16'h4440);
    for (int i = 12; i < 16; i++) run_vec(i);
    chk("full push_ready", bus.o_push_ready, 0);
    chk("full tree_count", bus.o_tree_count, 16'h4444);
    step(1, 1, 5, 5, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("pop on full no grant", {bus.o_pop_valid, bus.o_pop_empty}, 0);

    // WRR with unit weights, then weight[1]=2.
    idle(0, 0);
    for (int i = 0; i < 12; i++) run_vec(i);
    for (int i = 16; i < 28; i++) run_vec(i);
    chk("wrr drained counts", bus.o_tree_count, 0);
    for (int i = 0; i < 12; i++) idle(1);
    step(0, 0, 0, 0, 0, 1, 1, 1, 2);
    for (int i = 0; i < 12; i++) run_vec(i);
    for (int i = 28; i < 32; i++) run_vec(i);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 1);

    // Pop with every tree empty.
    idle(0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("empty pop_empty", bus.o_pop_empty, 1);
    chk("empty pop_valid", bus.o_pop_valid, 0);
    chk("empty fifo_count", bus.o_fifo_count, 0);

    // Simultaneous push and pop: pop wins, push retried, order pop then push.
    idle(0, 0);
    step(1, 1, 7, 11, 0, 0);
    step(1, 2, 9, 22, 1, 0);
    chk("collide pop_valid", bus.o_pop_valid, 1);
    chk("collide pop_tree", bus.o_pop_tree_id, 1);
    chk("collide fifo_count", bus.o_fifo_count, 2);
    step(1, 2, 9, 22, 0, 0);
    chk("retry fifo_count", bus.o_fifo_count, 3);
    idle(1);
    chk("order head is pop", {bus.o_cmd_push, bus.o_cmd_tree_id}, {1'b0, 2'd1});
    idle(1);
    chk("order then push", {bus.o_cmd_push, bus.o_cmd_tree_id, bus.o_cmd_data},
        {1'b1, 2'd2, 18'd22});

    // Mid-operation reset discards queued commands.
    idle(0, 0);
    for (int i = 0; i < 5; i++) step(1, i % TN, i, 100 + i, 0, 0);
    idle(0, 0);
    chk("midreset fifo_count", bus.o_fifo_count, 0);
    chk("midreset cmd_valid", bus.o_cmd_valid, 0);
    chk("midreset tree_count", bus.o_tree_count, 0);

    // Saturated counter drops the push and sets the sticky flag.
    idle(0, 0);
    for (int i = 0; i < 16; i++) step(1, 2, i, i, 0, 1);
    chk("sat overflow", bus.o_overflow, 1);
    chk("sat tree_count", bus.o_tree_count, 16'h0F00);

    // Randomized traffic against the model.
    idle(0, 0);
    for (int i = 0; i < 3000; i++) begin
      int rdy_pct;
      rdy_pct = 30 + 20 * ((i / 500) % 3);
      step($urandom_range(0, 1), $urandom_range(0, TN - 1), $urandom_range(0, 65535),
           $urandom_range(0, (1 << (MTW + PTW)) - 1), $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 19) == 0,
           $urandom_range(0, TN - 1), $urandom_range(0, 3), $urandom_range(0, 199) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
